// File: rtl/data_memory_io.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_io
// Description : CPU data-port memory plus memory-mapped I/O block.
//               Word-addressed RAM in the low address space; with the I/O
//               select bit set, a small register file is mapped instead
//               (keys, switches, LEDs, hex display, key edge capture and an
//               interval timer). Drives one level-sensitive interrupt.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               wrtEn    - write strobe for the current address
//               addr     - byte address (word index = addr[TRUE_ADDR+1:2])
//               dIn      - write data
//               key      - raw keys, active-low, asynchronous
//               sw       - raw switches, asynchronous
//               dOut     - read data for the address captured last falling edge
//               ledr     - LED register
//               hex      - hex display register
//               irq      - interrupt request (level)
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_io #(
    parameter int ADDR_BIT_WIDTH      = 32,
    parameter int DATA_BIT_WIDTH      = 32,
    parameter int TRUE_ADDR_BIT_WIDTH = 11,
    parameter int IO_BIT              = 29,
    parameter int N_KEY               = 4,
    parameter int N_SW                = 10,
    parameter int N_LEDR              = 10,
    parameter int HEX_BIT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES     = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wrtEn,
    input  logic [ADDR_BIT_WIDTH-1:0] addr,
    input  logic [DATA_BIT_WIDTH-1:0] dIn,
    input  logic [N_KEY-1:0]          key,
    input  logic [N_SW-1:0]           sw,
    output logic [DATA_BIT_WIDTH-1:0] dOut,
    output logic [N_LEDR-1:0]         ledr,
    output logic [HEX_BIT_WIDTH-1:0]  hex,
    output logic                      irq
);

    localparam int c_DEPTH = 1 << TRUE_ADDR_BIT_WIDTH;
    localparam int c_NIN   = N_KEY + N_SW;
    localparam int c_DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    // Keys are active-low on the pins; invert them after synchronising.
    localparam logic [c_NIN-1:0]  c_INV     = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [TRUE_ADDR_BIT_WIDTH-1:0] w_word;
    logic                           w_is_io;
    logic [2:0]                     w_off;
    logic [7:0]                     w_wr;
    logic                           w_unused_addr;

    assign w_word        = addr[TRUE_ADDR_BIT_WIDTH+1:2];
    assign w_is_io       = addr[IO_BIT];
    assign w_off         = addr[4:2];
    assign w_wr          = (wrtEn && w_is_io) ? (8'b1 << w_off) : 8'b0;
    assign w_unused_addr = ^addr;

    // ------------------------------------------------------------------
    // RAM, written on the falling edge; contents are never reset.
    // ------------------------------------------------------------------
    logic [DATA_BIT_WIDTH-1:0]      r_mem [c_DEPTH];
    logic [TRUE_ADDR_BIT_WIDTH-1:0] r_rd_word;
    logic                           r_rd_io;
    logic [DATA_BIT_WIDTH-1:0]      r_io_rdata;
    logic [DATA_BIT_WIDTH-1:0]      w_io_rdata;

    always_ff @(negedge clk) begin
        if (wrtEn && !w_is_io) r_mem[w_word] <= dIn;
    end

    // The I/O read value is snapshotted on the same falling edge as the
    // address so that a register written on the following rising edge still
    // presents its old value for the rest of the access cycle.
    always_ff @(negedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_word  <= '0;
            r_rd_io    <= 1'b0;
            r_io_rdata <= '0;
        end else begin
            r_rd_word  <= w_word;
            r_rd_io    <= w_is_io;
            r_io_rdata <= w_io_rdata;
        end
    end

    // Read is asynchronous after the falling-edge write, so a same-cycle
    // write and read of one word return the new data.
    assign dOut = r_rd_io ? r_io_rdata : r_mem[r_rd_word];

    // ------------------------------------------------------------------
    // Synchronisers and per-bit debounce
    // ------------------------------------------------------------------
    logic [c_NIN-1:0] r_sync1;
    logic [c_NIN-1:0] r_sync2;
    logic [c_NIN-1:0] w_sync;
    logic [c_NIN-1:0] w_deb;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw, key};
            r_sync2 <= r_sync1;
        end
    end
    assign w_sync = r_sync2 ^ c_INV;

    for (genvar gi = 0; gi < c_NIN; gi++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_bit;

        // Counts consecutive clocks of disagreement; any agreement restarts it.
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (w_sync[gi] != r_bit) begin
                if (r_cnt == c_DB_LAST) begin
                    r_bit <= w_sync[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
        assign w_deb[gi] = r_bit;
    end

    logic [N_KEY-1:0] w_keys;
    logic [N_SW-1:0]  w_sws;
    assign w_keys = w_deb[N_KEY-1:0];
    assign w_sws  = w_deb[c_NIN-1:N_KEY];

    // ------------------------------------------------------------------
    // I/O registers and timer (rising edge)
    // ------------------------------------------------------------------
    logic [N_KEY-1:0]          r_keys_prev;
    logic [N_KEY-1:0]          r_kedge;
    logic [N_LEDR-1:0]         r_ledr;
    logic [HEX_BIT_WIDTH-1:0]  r_hex;
    logic [DATA_BIT_WIDTH-1:0] r_tcount;
    logic [DATA_BIT_WIDTH-1:0] r_tlimit;
    logic                      r_t_en;
    logic                      r_t_ar;
    logic                      r_t_ie;
    logic                      r_t_exp;

    logic [N_KEY-1:0]          w_key_rise;
    logic [N_KEY-1:0]          w_kedge_clr;
    logic                      w_t_match;
    logic                      w_t_hit;

    assign w_key_rise  = w_keys & ~r_keys_prev;
    assign w_kedge_clr = w_wr[4] ? dIn[N_KEY-1:0] : '0;
    assign w_t_match   = (r_tcount == r_tlimit);
    assign w_t_hit     = r_t_en && w_t_match;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_keys_prev <= '0;
            r_kedge     <= '0;
            r_ledr      <= '0;
            r_hex       <= '0;
            r_tcount    <= '0;
            r_tlimit    <= '0;
            r_t_en      <= 1'b0;
            r_t_ar      <= 1'b0;
            r_t_ie      <= 1'b0;
            r_t_exp     <= 1'b0;
        end else begin
            r_keys_prev <= w_keys;
            // New edges win over a same-cycle clear.
            r_kedge     <= (r_kedge & ~w_kedge_clr) | w_key_rise;

            if (w_wr[2]) r_ledr   <= dIn[N_LEDR-1:0];
            if (w_wr[3]) r_hex    <= dIn[HEX_BIT_WIDTH-1:0];
            if (w_wr[6]) r_tlimit <= dIn;

            // A CPU write to the count takes priority over the timer.
            if (w_wr[5]) begin
                r_tcount <= dIn;
            end else if (r_t_en) begin
                if (w_t_match) begin
                    if (r_t_ar) r_tcount <= '0;
                end else begin
                    r_tcount <= r_tcount + 1'b1;
                end
            end

            if (w_wr[7]) begin
                r_t_en <= dIn[0];
                r_t_ar <= dIn[1];
                r_t_ie <= dIn[2];
            end else if (w_t_hit && !r_t_ar) begin
                r_t_en <= 1'b0;
            end

            r_t_exp <= (r_t_exp & ~(w_wr[7] & dIn[3])) | w_t_hit;
        end
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            3'd0: w_io_rdata[N_KEY-1:0]         = w_keys;
            3'd1: w_io_rdata[N_SW-1:0]          = w_sws;
            3'd2: w_io_rdata[N_LEDR-1:0]        = r_ledr;
            3'd3: w_io_rdata[HEX_BIT_WIDTH-1:0] = r_hex;
            3'd4: w_io_rdata[N_KEY-1:0]         = r_kedge;
            3'd5: w_io_rdata                    = r_tcount;
            3'd6: w_io_rdata                    = r_tlimit;
            default: w_io_rdata[3:0]            = {r_t_exp, r_t_ie, r_t_ar, r_t_en};
        endcase
    end

    assign ledr = r_ledr;
    assign hex  = r_hex;
    assign irq  = (|r_kedge) | (r_t_exp & r_t_ie);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_io
// Description : Scoreboard bench for data_memory_io. Every bus cycle pushes
//               the expected dOut / ledr / hex / irq from a behavioural model;
//               a monitor pops and compares after each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_io;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TAW = 11;
    localparam int IOB = 29;
    localparam int NK  = 4;
    localparam int NSW = 10;
    localparam int NL  = 10;
    localparam int HW  = 16;
    localparam int DB  = 8;
    localparam int NIN = NK + NSW;
    localparam logic [NIN-1:0] INV = {{NSW{1'b0}}, {NK{1'b1}}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wrtEn;
    logic [AW-1:0] addr;
    logic [DW-1:0] dIn;
    logic [NK-1:0] key;
    logic [NSW-1:0] sw;
    logic [DW-1:0] dOut;
    logic [NL-1:0] ledr;
    logic [HW-1:0] hex;
    logic          irq;

    data_memory_io #(
        .ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .TRUE_ADDR_BIT_WIDTH(TAW),
        .IO_BIT(IOB), .N_KEY(NK), .N_SW(NSW), .N_LEDR(NL),
        .HEX_BIT_WIDTH(HW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wrtEn(wrtEn), .addr(addr), .dIn(dIn),
        .key(key), .sw(sw), .dOut(dOut), .ledr(ledr), .hex(hex), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             rd;
        logic [DW-1:0]  d;
        logic [NL-1:0]  led;
        logic [HW-1:0]  hx;
        bit             irq;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_act = 1'b0;

    // ---------------- reference model ----------------
    logic [DW-1:0]  m_ram [int];
    logic [NL-1:0]  m_ledr;
    logic [HW-1:0]  m_hex;
    logic [NIN-1:0] m_deb;        // debounced {switches, keys pressed}
    logic [NK-1:0]  m_keys_last;
    logic [NK-1:0]  m_kedge;
    logic [DW-1:0]  m_cnt, m_lim;
    bit             m_en, m_ar, m_ie, m_exp;
    logic [NIN-1:0] p0, p1;       // raw samples still in the synchroniser
    logic [NIN-1:0] hist[$];      // last DB synchronised samples

    function automatic bit m_irq();
        return (|m_kedge) || (m_exp && m_ie);
    endfunction

    function automatic logic [DW-1:0] io_read(input logic [2:0] off);
        logic [DW-1:0] v;
        v = '0;
        case (off)
            3'd0: v[NK-1:0]  = m_deb[NK-1:0];
            3'd1: v[NSW-1:0] = m_deb[NIN-1:NK];
            3'd2: v[NL-1:0]  = m_ledr;
            3'd3: v[HW-1:0]  = m_hex;
            3'd4: v[NK-1:0]  = m_kedge;
            3'd5: v          = m_cnt;
            3'd6: v          = m_lim;
            default: v[3:0]  = {m_exp, m_ie, m_ar, m_en};
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_ledr = '0; m_hex = '0; m_deb = '0; m_keys_last = '0; m_kedge = '0;
        m_cnt = '0; m_lim = '0; m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        p0 = '0; p1 = '0; hist.delete();
    endtask

    // One rising edge of the I/O side, all updates from pre-edge state.
    task automatic model_step(input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [NIN-1:0] raw);
        logic [NIN-1:0] seen;
        logic [NK-1:0]  rise, clr;
        logic [2:0]     off;
        bit io, hit, all_diff;
        seen = p1 ^ INV;
        p1 = p0;
        p0 = raw;
        hist.push_back(seen);
        if (hist.size() > DB) void'(hist.pop_front());
        rise = m_deb[NK-1:0] & ~m_keys_last;
        m_keys_last = m_deb[NK-1:0];
        // A debounced bit flips once the last DB samples all disagree with it.
        if (hist.size() == DB) begin
            for (int b = 0; b < NIN; b++) begin
                all_diff = 1;
                foreach (hist[j]) if (hist[j][b] == m_deb[b]) all_diff = 0;
                if (all_diff) m_deb[b] = ~m_deb[b];
            end
        end
        io  = we && a[IOB];
        off = a[4:2];
        clr = (io && off == 3'd4) ? d[NK-1:0] : '0;
        m_kedge = (m_kedge & ~clr) | rise;
        if (io && off == 3'd2) m_ledr = d[NL-1:0];
        if (io && off == 3'd3) m_hex  = d[HW-1:0];
        hit = m_en && (m_cnt == m_lim);
        if (io && off == 3'd5)      m_cnt = d;
        else if (hit)               m_cnt = m_ar ? '0 : m_cnt;
        else if (m_en)              m_cnt = m_cnt + 1;
        if (io && off == 3'd6) m_lim = d;
        m_exp = (m_exp && !(io && off == 3'd7 && d[3])) || hit;
        if (io && off == 3'd7) begin
            m_en = d[0]; m_ar = d[1]; m_ie = d[2];
        end else if (hit && !m_ar) begin
            m_en = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_act) begin
                if (q.size() == 0) begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    if (e.rd) check("dOut", dOut, e.d);
                    check("ledr", DW'(ledr), DW'(e.led));
                    check("hex",  DW'(hex),  DW'(e.hx));
                    check("irq",  DW'(irq),  DW'(e.irq));
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    function automatic logic [AW-1:0] io_a(input int off);
        logic [AW-1:0] a;
        a = '0;
        a[IOB] = 1'b1;
        a[4:2] = off[2:0];
        return a;
    endfunction

    function automatic logic [AW-1:0] ram_a(input int w);
        logic [AW-1:0] a;
        a = '0;
        a[TAW+1:2] = w[TAW-1:0];
        return a;
    endfunction

    task automatic cyc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   w;
        w = int'(a[TAW+1:2]);
        wrtEn = we; addr = a; dIn = d;
        if (we && !a[IOB]) m_ram[w] = d;
        e.rd = 0; e.d = '0;
        if (a[IOB]) begin
            e.rd = 1; e.d = io_read(a[4:2]);
        end else if (m_ram.exists(w)) begin
            e.rd = 1; e.d = m_ram[w];
        end
        e.led = m_ledr; e.hx = m_hex; e.irq = m_irq();
        q.push_back(e);
        mon_act = 1;
        @(posedge clk);
        model_step(we, a, d, {sw, key});
        #1;
        mon_act = 0;
    endtask

    task automatic do_reset();
        mon_act = 0;
        wrtEn   = 0;
        reset_n = 0;
        model_reset();
        #1;
        check("rst_ledr", DW'(ledr), DW'(m_ledr));
        check("rst_hex",  DW'(hex),  DW'(m_hex));
        check("rst_irq",  DW'(irq),  DW'(m_irq()));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            k;
        reset_n = 1; wrtEn = 0; addr = '0; dIn = '0; key = '1; sw = '0;
        #2;
        do_reset();

        // Reset state of every I/O register.
        for (int i = 0; i < 8; i++) cyc(0, io_a(i), '0);

        // RAM path, including the top word and an unwritten word.
        cyc(1, ram_a(5), 32'hDEADBEEF);
        cyc(1, ram_a(2047), 32'h1);
        cyc(0, ram_a(5), '0);
        cyc(0, ram_a(2047), '0);
        cyc(0, ram_a(0), '0);

        // LED / HEX width clipping, then reset mid-run.
        cyc(1, io_a(2), 32'hFFFFFFFF);
        cyc(1, io_a(3), 32'hFFFFFFFF);
        cyc(0, io_a(2), '0);
        cyc(0, io_a(3), '0);
        do_reset();
        cyc(0, io_a(2), '0);
        cyc(0, ram_a(5), '0);
        cyc(0, ram_a(2047), '0);

        // Key debounce with bounce glitches on key[1].
        for (int i = 0; i < 6; i++) begin
            key[1] = i[0];
            cyc(0, io_a(0), '0);
        end
        key[1] = 1'b0;
        for (int i = 0; i < 14; i++) cyc(0, io_a(0), '0);
        cyc(0, io_a(4), '0);
        cyc(1, io_a(4), 32'h2);
        cyc(0, io_a(4), '0);

        // Clear coinciding with a fresh edge: the edge must win.
        key[1] = 1'b1;
        for (int i = 0; i < 40 && m_deb[1]; i++) cyc(0, io_a(0), '0);
        key[1] = 1'b0;
        for (int i = 0; i < 40 && !m_deb[1]; i++) cyc(0, io_a(4), '0);
        cyc(1, io_a(4), 32'h2);
        cyc(0, io_a(4), '0);
        cyc(1, io_a(4), 32'hF);
        cyc(0, io_a(4), '0);

        // One-shot timer: limit 3, enable + irq-enable.
        cyc(1, io_a(6), 32'd3);
        cyc(1, io_a(7), 32'h5);
        for (int i = 0; i < 7; i++) cyc(0, io_a(i[0] ? 5 : 7), '0);
        cyc(1, io_a(7), 32'h8);
        cyc(0, io_a(7), '0);

        // Auto-reload with limit 0, then CPU write racing a timer update.
        cyc(1, io_a(5), 32'd0);
        cyc(1, io_a(6), 32'd0);
        cyc(1, io_a(7), 32'h3);
        for (int i = 0; i < 4; i++) cyc(0, io_a(i[0] ? 5 : 7), '0);
        cyc(1, io_a(5), 32'd7);
        cyc(0, io_a(5), '0);
        cyc(1, io_a(7), 32'h8);
        cyc(0, io_a(7), '0);

        // Randomised traffic over RAM and I/O with moving keys/switches.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 29) == 0) sw[$urandom_range(0, NSW-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) key[$urandom_range(0, NK-1)] ^= 1'b1;
            a = $urandom;
            d = $urandom;
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: a[TAW+1:2] = '0;
                1: a[TAW+1:2] = '1;
                2: a[TAW+1:2] = TAW'(5);
                default: a[TAW+1:2] = TAW'($urandom_range(0, 15));
            endcase
            if (k < 2) begin
                a[IOB] = 1'b0;
                cyc(k == 0, a, d);
            end else begin
                a[IOB] = 1'b1;
                if (a[4:2] == 3'd5 || a[4:2] == 3'd6) d = DW'($urandom_range(0, 12));
                cyc(k == 2, a, d);
            end
        end
        cyc(0, ram_a(5), '0);
        cyc(0, ram_a(2047), '0);

        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_io.md
# data_memory_io

Parametrised data memory plus memory-mapped I/O block for the CPU data port. Word-addressed RAM occupies the low address space. Setting the I/O select bit maps a register file instead: LEDs, hex display, debounced keys and switches, a key edge-capture register and an interval timer. The block also drives one interrupt line.

## Interface
- ADDR_BIT_WIDTH, 32, CPU address width
- DATA_BIT_WIDTH, 32, data width (≥16)
- TRUE_ADDR_BIT_WIDTH, 11, RAM word-address width; depth = 2^TRUE_ADDR_BIT_WIDTH
- IO_BIT, 29, address bit selecting I/O space
- N_KEY, 4, key count
- N_SW, 10, switch count
- N_LEDR, 10, LED count
- HEX_BIT_WIDTH, 16, hex display register width
- DEBOUNCE_CYCLES, 1000, stable cycles required before a debounced input changes (≥1)
- clk  in  1  system clock
- reset_n  in  1  reset: one clock; reset is asynchronous and active-low
- wrtEn  in  1  write strobe for the current address
- addr  in  ADDR_BIT_WIDTH  byte address; word index = addr[TRUE_ADDR_BIT_WIDTH+1:2]
- dIn  in  DATA_BIT_WIDTH  write data
- key  in  N_KEY  raw keys, active-low, asynchronous
- sw  in  N_SW  raw switches, asynchronous
- dOut  out  DATA_BIT_WIDTH  read data
- ledr  out  N_LEDR  LED register
- hex  out  HEX_BIT_WIDTH  hex display register
- irq  out  1  interrupt request, level

## Operation
- RAM region (addr[IO_BIT]=0): falling edge of clk writes dIn into the word when wrtEn=1. RAM contents are not reset.
- Every falling edge captures the word index and the I/O select into a read-address register, in both regions.
- dOut is the RAM word or I/O register selected by that captured address.
- I/O region (addr[IO_BIT]=1): register offset = addr[4:2]. Writes occur on the rising edge when wrtEn=1.
  - 0 KEYS, RO: debounced keys, pressed=1.
  - 1 SWS, RO: debounced switches.
  - 2 LEDR, RW: width N_LEDR.
  - 3 HEX, RW: width HEX_BIT_WIDTH.
  - 4 KEYEDGE, RW1C: sticky bit per key, set on a debounced 0→1 transition. Writing 1 clears the bit. A set and a clear in the same cycle leaves the bit set.
  - 5 TCOUNT, RW: timer count. A CPU write overrides a same-cycle timer update.
  - 6 TLIMIT, RW: timer limit.
  - 7 TCTRL, RW:
    - bit0 enable.
    - bit1 auto-reload.
    - bit2 irq-enable.
    - bit3 expired: sticky, W1C; a set and a clear in the same cycle leaves it set.
- Register widths: upper bits read 0, and writes to them are ignored.
- Debounce, per bit:
  - Two-flop synchroniser; keys are inverted after synchronising.
  - The debounced value takes the synchronised value once they have differed for DEBOUNCE_CYCLES consecutive clocks.
  - Any agreement before then resets that bit's counter to 0.
- Timer, each rising edge with enable=1:
  - count==limit, auto-reload=1: count←0, expired←1.
  - count==limit, auto-reload=0: count holds, enable←0, expired←1.
  - Otherwise count←count+1, wrapping at 2^DATA_BIT_WIDTH.
- irq = (|KEYEDGE) | (expired & irq-enable), combinational from registers.

## Timing
- Reset (async assert, released synchronously by the design): ledr=0, hex=0, KEYS=0, SWS=0, KEYEDGE=0, TCOUNT=0, TLIMIT=0, TCTRL=0, irq=0.
- Reset also clears the synchronisers and debounce counters, and sets the read-address register to RAM word 0.
- dOut is valid from the falling edge of the access cycle until the next falling edge.
- A RAM write and a read of the same word in one cycle return the new data.
- A read of an I/O register in the cycle it is written returns the pre-write value.
- Input-to-KEYS latency is 2 + DEBOUNCE_CYCLES clocks after the raw input goes stable. KEYEDGE sets 1 clock after KEYS rises.
- With limit=L and count=0, expired sets L+1 clocks after enable; period is L+1 clocks with auto-reload.
- L=0 with auto-reload expires every clock.
- Enabling with count>limit runs the counter through wrap before it matches.

## Test plan
- RAM path: write 0xDEADBEEF to word 5 and 0x1 to word 2047. Read both back → same values. Word 0 before any write is don't-care. Asserting reset_n=0 leaves RAM intact.
- LED/HEX path: write 0xFFFFFFFF to offsets 2 and 3 → ledr=0x3FF, hex=0xFFFF, readbacks 0x3FF/0xFFFF. Reset mid-run → both 0 immediately.
- Key debounce, DEBOUNCE_CYCLES=8:
  - key[1] low with 3-cycle bounce glitches → KEYS stays 0 until 10 stable clocks, then 0x2.
  - KEYEDGE=0x2 and irq=1.
  - Write 0x2 to offset 4 → KEYEDGE=0, irq=0.
  - A new edge in the same cycle as the clear leaves the bit set.
- Timer, one-shot: limit=3, ctrl=0x5 → expired at clock 4, count holds 3, enable reads 0, irq=1. Write 0x8 → expired=0, irq=0.
- Timer, auto-reload: limit=0, ctrl=0x3 → count stays 0 and expired sets every clock. A CPU write of 7 to TCOUNT in the same cycle as a timer update → reads 7.
- Unused offsets and I/O space: accesses never corrupt RAM.
